// File: rtl/cpu_types_pkg.sv
// Shared CPU types: MEM FSM state, SC result codes, EX/MEM bundle.
// Imported by ex_mem_stage and link_reg.
package cpu_types_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  localparam logic [31:0] SC_SUCCESS = 32'd1;
  localparam logic [31:0] SC_FAIL    = 32'd0;

  typedef struct packed {
    logic        regwrite;
    logic [1:0]  memtoreg;
    logic        ren;
    logic        wen;
    logic        atomic;
    logic        halt;
    logic [31:0] aluout;
    logic [31:0] storedata;
    logic [4:0]  wsel;
    logic [31:0] npc;
    logic [31:0] imemload;
    logic [31:0] sc_result;
  } ex_mem_t;

endpackage

// File: rtl/link_reg.sv
// LL/SC link register with set, clear and address-match ports.
// Ports: set/set_addr, clr, snoop_inv/snoop_addr, wr_done/wr_addr, match_addr -> match, valid, addr.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        set,
  input  logic [31:0] set_addr,
  input  logic        clr,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  input  logic        wr_done,
  input  logic [31:0] wr_addr,
  input  logic [31:0] match_addr,
  output logic        match,
  output logic        valid,
  output logic [31:0] addr
);

  logic        v_q;
  logic [31:0] a_q;
  logic        v_b;
  logic [31:0] a_b;
  logic        v_n;

  // v_b/a_b: link after this edge's LL set and address-based kills.
  // Address kills are checked against the new address so a snoop
  // racing an LL to the same line wins.
  always_comb begin
    v_b = set ? 1'b1 : v_q;
    a_b = set ? set_addr : a_q;
    if (snoop_inv && (snoop_addr == a_b)) v_b = 1'b0;
    if (wr_done && (wr_addr == a_b))      v_b = 1'b0;
  end

  // match sees the forwarded link so an SC right behind its LL works;
  // clr (SC done/fail) is applied after to avoid a loop through match.
  assign match = v_b && (a_b == match_addr);
  assign v_n   = v_b & ~clr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q <= 1'b0;
      a_q <= '0;
    end else begin
      v_q <= v_n;
      a_q <= a_b;
    end
  end

  assign valid = v_q;
  assign addr  = a_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus D-cache request FSM and LL/SC support.
// Ports: EX inputs, cache request/response + snoop, WB outputs, mem_stall.
module ex_mem_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        regwrite,
  input  logic [1:0]  memtoreg,
  input  logic        dmemREN_req,
  input  logic        dmemWEN_req,
  input  logic        datomic,
  input  logic        halt,
  input  logic [31:0] aluout,
  input  logic [31:0] storedata,
  input  logic [4:0]  wsel,
  input  logic [31:0] NPC,
  input  logic [31:0] imemload,
  input  logic        flush,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        regwrite_out,
  output logic [1:0]  memtoreg_out,
  output logic [4:0]  wsel_out,
  output logic [31:0] aluout_out,
  output logic [31:0] dmemload_out,
  output logic [31:0] sc_result,
  output logic        halt_out,
  output logic [31:0] NPC_out,
  output logic [31:0] imemload_out,
  output logic        mem_stall
);

  mem_state_t state;
  mem_state_t state_n;
  ex_mem_t    q;
  ex_mem_t    d;

  logic done;
  logic is_sc;
  logic sc_ok;
  logic sc_fail;
  logic start;
  logic lk_match;
  logic lk_valid;
  logic [31:0] lk_addr;

  assign done      = (state == REQ) & dhit;
  assign mem_stall = (state == REQ) & ~dhit;

  assign is_sc = dmemWEN_req & datomic;
  assign sc_ok = is_sc & lk_match & ~q.halt;

  // A failing SC never reaches the cache; it only kills the link.
  assign sc_fail = ~mem_stall & ~flush & is_sc & ~sc_ok;

  assign start = ~flush & ~q.halt &
    (dmemREN_req | (dmemWEN_req & ~datomic) | sc_ok);

  always_comb begin
    d = '0;
    if (!flush) begin
      d.regwrite  = regwrite;
      d.memtoreg  = memtoreg;
      d.ren       = dmemREN_req & start;
      d.wen       = dmemWEN_req & start;
      d.atomic    = datomic;
      d.halt      = halt;
      d.aluout    = aluout;
      d.storedata = storedata;
      d.wsel      = wsel;
      d.npc       = NPC;
      d.imemload  = imemload;
      d.sc_result = sc_ok ? SC_SUCCESS : SC_FAIL;
    end
  end

  always_comb begin
    state_n = state;
    if (!mem_stall) state_n = start ? REQ : IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      q     <= '0;
    end else begin
      state <= state_n;
      if (!mem_stall) q <= d;
    end
  end

  link_reg u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (done & q.ren & q.atomic),
    .set_addr   (q.aluout),
    .clr        ((done & q.wen & q.atomic) | sc_fail),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .wr_done    (done & q.wen),
    .wr_addr    (q.aluout),
    .match_addr (aluout),
    .match      (lk_match),
    .valid      (lk_valid),
    .addr       (lk_addr)
  );

  assign dmemREN      = (state == REQ) & q.ren;
  assign dmemWEN      = (state == REQ) & q.wen;
  assign dmemaddr     = q.aluout;
  assign dmemstore    = q.storedata;
  assign regwrite_out = q.regwrite;
  assign memtoreg_out = q.memtoreg;
  assign wsel_out     = q.wsel;
  assign aluout_out   = q.aluout;
  assign dmemload_out = dmemload;
  assign sc_result    = q.sc_result;
  assign halt_out     = q.halt;
  assign NPC_out      = q.npc;
  assign imemload_out = q.imemload;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: pass-through table plus
// multi-cycle load/store, LL/SC, flush, reset and halt sequences.
module tb_ex_mem_stage;

  logic        CLK;
  logic        nRST;
  logic        regwrite;
  logic [1:0]  memtoreg;
  logic        dmemREN_req;
  logic        dmemWEN_req;
  logic        datomic;
  logic        halt;
  logic [31:0] aluout;
  logic [31:0] storedata;
  logic [4:0]  wsel;
  logic [31:0] NPC;
  logic [31:0] imemload;
  logic        flush;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic        regwrite_out;
  logic [1:0]  memtoreg_out;
  logic [4:0]  wsel_out;
  logic [31:0] aluout_out;
  logic [31:0] dmemload_out;
  logic [31:0] sc_result;
  logic        halt_out;
  logic [31:0] NPC_out;
  logic [31:0] imemload_out;
  logic        mem_stall;

  int checks;
  int errors;

  ex_mem_stage dut (
    .CLK(CLK), .nRST(nRST),
    .regwrite(regwrite), .memtoreg(memtoreg),
    .dmemREN_req(dmemREN_req), .dmemWEN_req(dmemWEN_req),
    .datomic(datomic), .halt(halt),
    .aluout(aluout), .storedata(storedata),
    .wsel(wsel), .NPC(NPC), .imemload(imemload), .flush(flush),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
    .wsel_out(wsel_out), .aluout_out(aluout_out),
    .dmemload_out(dmemload_out), .sc_result(sc_result),
    .halt_out(halt_out), .NPC_out(NPC_out),
    .imemload_out(imemload_out), .mem_stall(mem_stall)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rw;
    logic [1:0]  mtr;
    logic [4:0]  ws;
    logic [31:0] alu;
    logic [31:0] npc;
    logic [31:0] iml;
    logic        fl;
    logic        e_rw;
    logic [1:0]  e_mtr;
    logic [4:0]  e_ws;
    logic [31:0] e_alu;
    logic [31:0] e_npc;
    logic [31:0] e_iml;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic nop();
    regwrite = 0; memtoreg = 0; dmemREN_req = 0; dmemWEN_req = 0;
    datomic = 0; halt = 0; aluout = 0; storedata = 0; wsel = 0;
    NPC = 0; imemload = 0; flush = 0;
  endtask

  task automatic ll(input logic [31:0] a);
    nop();
    regwrite = 1; memtoreg = 1; dmemREN_req = 1; datomic = 1;
    aluout = a; wsel = 5'd9;
  endtask

  int stalls;
  int rens;

  initial begin
    tbl[0] = '{1'b1, 2'd0, 5'd5, 32'h11, 32'h104, 32'h00A50533, 1'b0,
               1'b1, 2'd0, 5'd5, 32'h11, 32'h104, 32'h00A50533};
    tbl[1] = '{1'b0, 2'd2, 5'd31, 32'hFFFFFFFF, 32'h200, 32'h12345678, 1'b0,
               1'b0, 2'd2, 5'd31, 32'hFFFFFFFF, 32'h200, 32'h12345678};
    tbl[2] = '{1'b1, 2'd3, 5'd7, 32'hCAFEF00D, 32'h300, 32'h1, 1'b1,
               1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b1, 2'd1, 5'd1, 32'h0, 32'h4, 32'h13, 1'b0,
               1'b1, 2'd1, 5'd1, 32'h0, 32'h4, 32'h13};
    tbl[4] = '{1'b0, 2'd1, 5'd12, 32'h44, 32'h48, 32'h99, 1'b1,
               1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0};
    tbl[5] = '{1'b1, 2'd2, 5'd16, 32'h80000000, 32'hFFFFFFFC, 32'hFFFFFFFF, 1'b0,
               1'b1, 2'd2, 5'd16, 32'h80000000, 32'hFFFFFFFC, 32'hFFFFFFFF};

    checks = 0; errors = 0;
    nop();
    dhit = 0; dmemload = 0; snoop_inv = 0; snoop_addr = 0;
    nRST = 0;
    #12;
    chk("rst regwrite_out", {31'd0, regwrite_out}, 32'd0);
    chk("rst dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("rst mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst sc_result", sc_result, 32'd0);
    chk("rst aluout_out", aluout_out, 32'd0);
    chk("rst link_valid", {31'd0, dut.u_link.valid}, 32'd0);
    nRST = 1;
    tick();

    // Pass-through / flush table
    for (int i = 0; i < 6; i++) begin
      nop();
      regwrite = tbl[i].rw; memtoreg = tbl[i].mtr; wsel = tbl[i].ws;
      aluout = tbl[i].alu; NPC = tbl[i].npc; imemload = tbl[i].iml;
      flush = tbl[i].fl; storedata = 32'h5A5A5A5A;
      tick();
      chk($sformatf("v%0d regwrite", i), {31'd0, regwrite_out}, {31'd0, tbl[i].e_rw});
      chk($sformatf("v%0d memtoreg", i), {30'd0, memtoreg_out}, {30'd0, tbl[i].e_mtr});
      chk($sformatf("v%0d wsel", i), {27'd0, wsel_out}, {27'd0, tbl[i].e_ws});
      chk($sformatf("v%0d aluout", i), aluout_out, tbl[i].e_alu);
      chk($sformatf("v%0d NPC", i), NPC_out, tbl[i].e_npc);
      chk($sformatf("v%0d imemload", i), imemload_out, tbl[i].e_iml);
      chk($sformatf("v%0d dmemREN", i), {31'd0, dmemREN}, 32'd0);
    end

    // LW 0x100, dhit after three waiting cycles
    nop();
    regwrite = 1; memtoreg = 1; dmemREN_req = 1; aluout = 32'h100;
    tick();
    nop();
    stalls = 0; rens = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_stall) stalls++;
      if (dmemREN) rens++;
      chk("lw addr", dmemaddr, 32'h100);
      tick();
    end
    dhit = 1; dmemload = 32'hDEADBEEF;
    #1;
    chk("lw stall count", stalls, 3);
    chk("lw ren count", rens, 3);
    chk("lw release stall", {31'd0, mem_stall}, 32'd0);
    chk("lw dmemload_out", dmemload_out, 32'hDEADBEEF);
    tick();
    dhit = 0;
    #1;
    chk("lw idle ren", {31'd0, dmemREN}, 32'd0);

    // LL 0x200 then SC 0x200 data 5
    ll(32'h200);
    tick();
    nop(); dhit = 1;
    tick();
    dhit = 0;
    chk("ll link_valid", {31'd0, dut.u_link.valid}, 32'd1);
    regwrite = 1; dmemWEN_req = 1; datomic = 1; aluout = 32'h200;
    storedata = 32'h5;
    tick();
    nop();
    chk("sc dmemWEN", {31'd0, dmemWEN}, 32'd1);
    chk("sc dmemstore", dmemstore, 32'h5);
    chk("sc result ok", sc_result, 32'd1);
    chk("sc stall", {31'd0, mem_stall}, 32'd1);
    dhit = 1;
    tick();
    dhit = 0;
    chk("sc link cleared", {31'd0, dut.u_link.valid}, 32'd0);
    chk("sc wen off", {31'd0, dmemWEN}, 32'd0);

    // LL 0x200, snoop kills link, SC fails
    ll(32'h200);
    tick();
    nop(); dhit = 1;
    tick();
    dhit = 0; snoop_inv = 1; snoop_addr = 32'h200;
    tick();
    snoop_inv = 0;
    chk("snoop link_valid", {31'd0, dut.u_link.valid}, 32'd0);
    regwrite = 1; dmemWEN_req = 1; datomic = 1; aluout = 32'h200;
    storedata = 32'h7;
    tick();
    nop();
    chk("scf dmemWEN", {31'd0, dmemWEN}, 32'd0);
    chk("scf stall", {31'd0, mem_stall}, 32'd0);
    chk("scf result", sc_result, 32'd0);
    chk("scf regwrite", {31'd0, regwrite_out}, 32'd1);

    // LL set and snoop to same address in the same edge
    ll(32'h400);
    tick();
    nop(); dhit = 1; snoop_inv = 1; snoop_addr = 32'h400;
    tick();
    dhit = 0; snoop_inv = 0;
    chk("ll+snoop link_valid", {31'd0, dut.u_link.valid}, 32'd0);

    // Flush while waiting in REQ is ignored
    nop();
    regwrite = 1; memtoreg = 1; dmemREN_req = 1; aluout = 32'h100; wsel = 5'd3;
    tick();
    nop();
    flush = 1; regwrite = 1; aluout = 32'h999;
    tick();
    chk("flush-stall regwrite", {31'd0, regwrite_out}, 32'd1);
    chk("flush-stall aluout", aluout_out, 32'h100);
    chk("flush-stall ren", {31'd0, dmemREN}, 32'd1);
    nop(); dhit = 1;
    tick();
    dhit = 0;
    chk("flush-stall done", {31'd0, dmemREN}, 32'd0);

    // Reset in the middle of a request
    ll(32'h600);
    tick();
    nop(); dhit = 1;
    tick();
    dhit = 0;
    regwrite = 1; dmemREN_req = 1; aluout = 32'h500;
    tick();
    nop();
    chk("pre-rst ren", {31'd0, dmemREN}, 32'd1);
    nRST = 0;
    #1;
    chk("rst ren", {31'd0, dmemREN}, 32'd0);
    chk("rst stall", {31'd0, mem_stall}, 32'd0);
    chk("rst state", {31'd0, dut.state}, 32'd0);
    chk("rst link", {31'd0, dut.u_link.valid}, 32'd0);
    #2;
    nRST = 1;
    tick();
    chk("no retry ren", {31'd0, dmemREN}, 32'd0);

    // Back-to-back SW 0x300, LW 0x304 hit first cycle
    nop();
    dmemWEN_req = 1; aluout = 32'h300; storedata = 32'hAA;
    tick();
    chk("sw wen", {31'd0, dmemWEN}, 32'd1);
    chk("sw addr", dmemaddr, 32'h300);
    dhit = 1;
    nop();
    regwrite = 1; memtoreg = 1; dmemREN_req = 1; aluout = 32'h304;
    #1;
    chk("sw stall", {31'd0, mem_stall}, 32'd0);
    tick();
    nop();
    chk("b2b state", {31'd0, dut.state}, 32'd1);
    chk("lw2 ren", {31'd0, dmemREN}, 32'd1);
    chk("lw2 addr", dmemaddr, 32'h304);
    chk("lw2 stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dhit = 0;
    chk("b2b idle", {31'd0, dut.state}, 32'd0);

    // Halt blocks later accesses
    nop(); halt = 1;
    tick();
    chk("halt_out", {31'd0, halt_out}, 32'd1);
    nop();
    regwrite = 1; dmemREN_req = 1; aluout = 32'h700;
    tick();
    nop();
    chk("halt no ren", {31'd0, dmemREN}, 32'd0);
    chk("halt no stall", {31'd0, mem_stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have ports: CLK in 1, clock; nRST in 1, reset, asynchronous, active-low.
REQ-002 SHALL have EX-side inputs: regwrite 1; memtoreg 2; dmemREN_req 1; dmemWEN_req 1; datomic 1 (LL when REN, SC when WEN); halt 1; aluout 32 (address/result); storedata 32; wsel 5; NPC 32; imemload 32; flush 1.
REQ-003 SHALL have cache-side ports: dmemREN out 1; dmemWEN out 1; dmemaddr out 32; dmemstore out 32; dhit in 1; dmemload in 32; snoop_inv in 1; snoop_addr in 32.
REQ-004 SHALL have WB-side outputs: regwrite_out 1; memtoreg_out 2; wsel_out 5; aluout_out 32; dmemload_out 32; sc_result 32; halt_out 1; NPC_out 32; imemload_out 32; mem_stall 1 (freezes all upstream latches).

Function
REQ-005 Stage register SHALL capture all EX inputs on posedge CLK when mem_stall=0; SHALL hold when mem_stall=1.
REQ-006 flush=1 with mem_stall=0 SHALL load a bubble (all stage fields 0); flush during mem_stall=1 SHALL be ignored.
REQ-007 FSM states IDLE, REQ; IDLE->REQ when an access is latched (REQ-009); REQ->IDLE on dhit unless a new access is latched in the same edge (stay REQ).
REQ-008 dmemREN/dmemWEN SHALL equal the latched REN/WEN only in REQ, else 0; dmemaddr=aluout_out, dmemstore=latched storedata, both unmodified 32-bit.
REQ-009 An access SHALL be latched for REN, plain WEN, or SC with link_valid=1 and link_addr==aluout; a failing SC SHALL NOT enter REQ and SHALL issue no write.
REQ-010 mem_stall SHALL be (state==REQ) & ~dhit, combinational; zero-latency release on dhit.
REQ-011 dmemload_out SHALL pass dmemload through combinationally; WB latch samples it when mem_stall=0.
REQ-012 Link register: LL completion (dhit in REQ) SHALL set link_valid=1, link_addr=aluout_out.
REQ-013 link_valid SHALL clear on: snoop_inv with snoop_addr==link_addr; local WEN completion (plain or SC) to link_addr; any SC completion or SC failure.
REQ-014 Simultaneous LL set and snoop_inv to same address SHALL leave link_valid=0 (clear wins).
REQ-015 sc_result SHALL be 32'd1 for a successful SC, 32'd0 for a failed SC, 32'd0 for non-SC; registered alongside the stage.
REQ-016 halt_out SHALL register halt; once halt_out=1 no new access SHALL be started.
REQ-017 Address compare SHALL use full 32 bits; no alignment checks.

Reset
REQ-018 nRST=0 SHALL asynchronously force state=IDLE, link_valid=0, link_addr=0, every stage register and registered output 0; dmemREN=dmemWEN=mem_stall=0.
REQ-019 Reset mid-REQ SHALL abandon the access; no retry after release.

Structure
REQ-020 FSM state enum (IDLE, REQ) and the SC result constants SHALL live in cpu_types_pkg.
REQ-021 Link register/compare logic SHALL be one sub-module, link_reg, with set/clear/match ports.

Verification
REQ-022 LW aluout=0x100, dhit after 3 cycles -> dmemREN=1 three cycles, mem_stall=1 for exactly 3 cycles, dmemload_out=0xDEADBEEF in release cycle.
REQ-023 LL 0x200 then SC 0x200 data 0x5 -> dmemWEN=1, dmemstore=0x5, sc_result=1, link_valid=0 afterwards.
REQ-024 LL 0x200, snoop_inv addr 0x200, SC 0x200 -> no dmemWEN, sc_result=0, mem_stall never 1 for SC.
REQ-025 flush=1 while in REQ awaiting dhit -> access completes, flush dropped; flush with stall=0 -> all outputs 0 next cycle.
REQ-026 nRST low during REQ -> dmemREN=0 immediately, state IDLE, link_valid=0.
REQ-027 Back-to-back SW 0x300, LW 0x304, dhit each first cycle -> state stays REQ, one stall-free cycle each, addresses in order.
